// File: rtl/key_exp_multi.sv
// key_exp_multi: word-serial AES-128/192/256 key schedule. One schedule word
// is produced per cycle through a single 4-lane S-box, round keys are emitted
// in order, and an optional store keeps them for random-access read-back.
module key_exp_multi #(
    parameter int MAX_NK   = 8,
    parameter bit STORE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key,
    output logic         ready,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         done,
    output logic         err,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data
);

    localparam int         NR_MAX   = MAX_NK + 6;
    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    // GF(2^8) multiply by x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, so 0 maps to 0) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  nk, nr;          // key length and round count of the active request
    logic [5:0]  wi;              // index of the next schedule word to write
    logic [2:0]  pos;             // wi mod nk
    logic [7:0]  rcon;
    logic [4:0]  r_emit;          // next round to emit
    logic        store_valid;
    logic [3:0]  nr_last;         // Nr of the last completed expansion
    logic [31:0] win [0:7];       // circular window, word j lives in slot j mod 8

    logic [3:0]   req_nk, req_nr;
    logic         req_ok;
    logic         load, gen_we, emit, err_nxt, done_nxt;
    logic [31:0]  t_word, w_back, sb_in, sb_out, w_new;
    logic         key_step, sub_step;
    logic [2:0]   rk_base;
    logic [127:0] rk_word;

    // Decode the requested key length and check it against MAX_NK
    always_comb begin
        req_nk = 4'd0;
        req_nr = 4'd0;
        case (mode)
            2'd0:    begin req_nk = 4'd4; req_nr = 4'd10; end
            2'd1:    begin req_nk = 4'd6; req_nr = 4'd12; end
            2'd2:    begin req_nk = 4'd8; req_nr = 4'd14; end
            default: begin req_nk = 4'd0; req_nr = 4'd0;  end
        endcase
        req_ok = (mode != 2'd3) && (req_nk <= MAX_NK_W);
    end

    // Schedule word datapath: t = w[i-1], back = w[i-Nk]; for Nk=8 the back
    // slot is the one being overwritten, which is read before the write.
    assign t_word   = win[wi[2:0] - 3'd1];
    assign w_back   = win[wi[2:0] - nk[2:0]];
    assign key_step = (pos == 3'd0);
    assign sub_step = (nk == 4'd8) && (pos == 3'd4);
    assign sb_in    = key_step ? {t_word[23:0], t_word[31:24]} : t_word;
    assign sb_out   = {sbox(sb_in[31:24]), sbox(sb_in[23:16]),
                       sbox(sb_in[15:8]),  sbox(sb_in[7:0])};
    assign w_new    = key_step ? (w_back ^ sb_out ^ {rcon, 24'h0})
                    : sub_step ? (w_back ^ sb_out)
                    :            (w_back ^ t_word);

    // Round r occupies slots 0..3 (r even) or 4..7 (r odd)
    assign rk_base = {r_emit[0], 2'b00};
    assign rk_word = {win[rk_base], win[rk_base | 3'd1],
                      win[rk_base | 3'd2], win[rk_base | 3'd3]};

    // A round is emitted once its last word is in the window, in order
    assign emit  = (state != IDLE) && (r_emit <= {1'b0, nr})
                && ({1'b0, wi} >= ({r_emit, 2'b00} + 7'd4));
    assign ready = (state == IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        gen_we    = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        load      = 1'b1;
                        state_nxt = GEN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            GEN: begin
                gen_we = 1'b1;
                if (wi == {nr, 2'b11}) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_emit > {1'b0, nr}) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, round-key output register and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nk          <= 4'd0;
            nr          <= 4'd0;
            wi          <= 6'd0;
            pos         <= 3'd0;
            rcon        <= 8'h00;
            r_emit      <= 5'd0;
            rk_valid    <= 1'b0;
            rk_idx      <= 4'd0;
            rk_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            store_valid <= 1'b0;
            nr_last     <= 4'd0;
        end else begin
            rk_valid <= emit;
            done     <= done_nxt;
            err      <= err_nxt;
            if (load) begin
                nk          <= req_nk;
                nr          <= req_nr;
                wi          <= {2'b00, req_nk};
                pos         <= 3'd0;
                rcon        <= 8'h01;
                r_emit      <= 5'd0;
                store_valid <= 1'b0;
            end
            if (gen_we) begin
                wi  <= wi + 6'd1;
                pos <= (pos == nk[2:0] - 3'd1) ? 3'd0 : pos + 3'd1;
                if (key_step) rcon <= xtime(rcon);
            end
            if (emit) begin
                rk_idx  <= r_emit[3:0];
                rk_data <= rk_word;
                r_emit  <= r_emit + 5'd1;
            end
            if (done_nxt) begin
                store_valid <= STORE_EN;
                nr_last     <= nr;
            end
        end
    end

    // Window: bulk load of the cipher key, then one new word per GEN cycle
    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < 8; j++) win[j] <= key[255 - 32*j -: 32];
        end else if (gen_we) begin
            win[wi[2:0]] <= w_new;
        end
    end

    generate
        if (STORE_EN) begin : g_store
            logic [127:0] rk_store [0:NR_MAX];

            // Capture each round key as it is emitted
            always_ff @(posedge clk) begin
                if (emit) rk_store[r_emit[3:0]] <= rk_word;
            end

            // Registered read port, zero unless a complete expansion covers rd_idx
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= (store_valid && (rd_idx <= nr_last)) ? rk_store[rd_idx] : '0;
                end
            end
        end else begin : g_nostore
            logic unused_rd;
            assign unused_rd = ^{rd_en, rd_idx, store_valid, nr_last};
            assign rd_data   = '0;
        end
    endgenerate

endmodule
